// File: rtl/gpio_rotation_monitor_if.sv
// Signal bundle between the rotating GPIO pattern path and its rotation monitor.
// The master side drives the pattern and controls; the slave side is the monitor.
interface gpio_rotation_monitor_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] gpio_in;
    logic             enable;
    logic             clear;
    logic [CNT_W-1:0] rotations;
    logic [CNT_W-1:0] errors;
    logic [WIDTH-1:0] last_pattern;
    logic             locked;
    logic             err_pulse;
    logic             irq;

    modport master (
        output gpio_in,
        output enable,
        output clear,
        input  rotations,
        input  errors,
        input  last_pattern,
        input  locked,
        input  err_pulse,
        input  irq
    );

    modport slave (
        input  gpio_in,
        input  enable,
        input  clear,
        output rotations,
        output errors,
        output last_pattern,
        output locked,
        output err_pulse,
        output irq
    );
endinterface

// File: rtl/gpio_rotation_monitor.sv
// Checks a synchronized one-hot GPIO pattern for rotate-left steps, counting good steps
// and sequence errors, with a sticky error interrupt.
module gpio_rotation_monitor #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                    clk,
    input logic                    reset,
    gpio_rotation_monitor_if.slave bus
);

    typedef enum logic [0:0] {StWaitInit, StTrack} state_e;

    function automatic logic is_onehot(input logic [WIDTH-1:0] x);
        return (x != '0) && ((x & (x - WIDTH'(1))) == '0);
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] last_q;
    logic             change;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [CNT_W-1:0] rot_q, rot_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             irq_q, irq_d;
    logic             err_pulse_q, err_pulse_d;

    // Input synchronizer; the pattern may come from another clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            last_q <= '0;
        end else begin
            sync_q[0] <= bus.gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sample;
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];
    assign change = (sample != last_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StWaitInit;
            expected_q  <= '0;
            rot_q       <= '0;
            err_q       <= '0;
            irq_q       <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            rot_q       <= rot_d;
            err_q       <= err_d;
            irq_q       <= irq_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        rot_d       = rot_q;
        err_d       = err_q;
        irq_d       = irq_q;
        err_pulse_d = 1'b0;

        if (bus.clear) begin
            state_d = StWaitInit;
            rot_d   = '0;
            err_d   = '0;
            irq_d   = 1'b0;
        end else if (!bus.enable) begin
            state_d = StWaitInit;
        end else begin
            unique case (state_q)
                StWaitInit: begin
                    // Locking on a pattern is not itself a rotation step.
                    if (is_onehot(sample)) begin
                        expected_d = rotl(sample);
                        state_d    = StTrack;
                    end
                end
                StTrack: begin
                    if (change) begin
                        if (sample == expected_q) begin
                            rot_d      = sat_inc(rot_q);
                            expected_d = rotl(sample);
                        end else begin
                            err_d       = sat_inc(err_q);
                            err_pulse_d = 1'b1;
                            irq_d       = 1'b1;
                            state_d     = StWaitInit;
                        end
                    end
                end
                default: state_d = StWaitInit;
            endcase
        end
    end

    assign bus.rotations    = rot_q;
    assign bus.errors       = err_q;
    assign bus.last_pattern = last_q;
    assign bus.locked       = (state_q == StTrack);
    assign bus.err_pulse    = err_pulse_q;
    assign bus.irq          = irq_q;

endmodule

// File: tb/tb_gpio_rotation_monitor.sv
// Directed bench for gpio_rotation_monitor: a default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_gpio_rotation_monitor;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gpio_rotation_monitor_if #(.WIDTH(5), .CNT_W(16)) bus ();
    gpio_rotation_monitor_if #(.WIDTH(5), .CNT_W(4))  bus4 ();

    assign bus4.gpio_in = bus.gpio_in;
    assign bus4.enable  = bus.enable;
    assign bus4.clear   = bus.clear;

    gpio_rotation_monitor #(.WIDTH(5), .CNT_W(16), .SYNC_STAGES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    gpio_rotation_monitor #(.WIDTH(5), .CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] pat);
        @(negedge clk);
        bus.gpio_in = pat;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat;
        bus.gpio_in = 5'b10000;
        bus.enable  = 1'b1;
        bus.clear   = 1'b0;

        // Reset state
        #1;
        check("rst_rotations", bus.rotations, 0);
        check("rst_errors", bus.errors, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_err_pulse", bus.err_pulse, 0);
        check("rst_last_pattern", bus.last_pattern, 0);

        // Lock three edges after release
        @(negedge clk);
        reset = 1'b1;
        edges(2);
        check("lock_not_yet", bus.locked, 0);
        edges(1);
        check("lock_after_3", bus.locked, 1);
        check("lock_no_count", bus.rotations, 0);
        check("lock_last_pattern", bus.last_pattern, 32'h10);

        // Four clean rotations
        drive(5'b00001);
        edges(2);
        check("rot1_latency_hold", bus.rotations, 0);
        edges(1);
        check("rot1", bus.rotations, 1);
        edges(1);
        drive(5'b00010); edges(4);
        drive(5'b00100); edges(4);
        drive(5'b01000); edges(4);
        check("rot4_rotations", bus.rotations, 4);
        check("rot4_errors", bus.errors, 0);
        check("rot4_irq", bus.irq, 0);
        check("rot4_last_pattern", bus.last_pattern, 32'h08);

        // Reach 00010, then a reverse step
        drive(5'b10000); edges(4);
        drive(5'b00001); edges(4);
        drive(5'b00010); edges(4);
        check("pre_rev_rotations", bus.rotations, 7);
        drive(5'b00001);
        edges(2);
        check("rev_pulse_early", bus.err_pulse, 0);
        edges(1);
        check("rev_pulse", bus.err_pulse, 1);
        check("rev_errors", bus.errors, 1);
        check("rev_irq", bus.irq, 1);
        check("rev_unlocked", bus.locked, 0);
        check("rev_rotations", bus.rotations, 7);
        edges(1);
        check("rev_pulse_one_cycle", bus.err_pulse, 0);
        check("rev_relock", bus.locked, 1);
        drive(5'b00010); edges(3);
        check("rev_next_counts", bus.rotations, 8);
        check("rev_irq_sticky", bus.irq, 1);

        // Zero sample is an error and does not relock; 01000 relocks
        drive(5'b00000); edges(3);
        check("zero_errors", bus.errors, 2);
        check("zero_pulse", bus.err_pulse, 1);
        edges(1);
        check("zero_no_relock", bus.locked, 0);
        drive(5'b01000); edges(3);
        check("zero_relock", bus.locked, 1);
        check("zero_relock_no_count", bus.rotations, 8);
        drive(5'b10000); edges(3);
        check("zero_next_counts", bus.rotations, 9);
        check("zero_errors_hold", bus.errors, 2);

        // clear coincides with an error decision
        drive(5'b00100);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        edges(1);
        check("clr_errors", bus.errors, 0);
        check("clr_irq", bus.irq, 0);
        check("clr_pulse", bus.err_pulse, 0);
        check("clr_locked", bus.locked, 0);
        check("clr_rotations", bus.rotations, 0);
        @(negedge clk);
        bus.clear = 1'b0;
        edges(1);
        check("clr_relock", bus.locked, 1);
        drive(5'b01000); edges(3);
        check("clr_next_counts", bus.rotations, 1);

        // Disabled monitoring ignores rotations
        @(negedge clk);
        bus.enable = 1'b0;
        drive(5'b10000); edges(4);
        drive(5'b00001); edges(4);
        drive(5'b00010); edges(4);
        check("dis_rotations", bus.rotations, 1);
        check("dis_locked", bus.locked, 0);
        check("dis_errors", bus.errors, 0);
        @(negedge clk);
        bus.enable = 1'b1;
        edges(1);
        check("en_lock", bus.locked, 1);
        check("en_lock_no_count", bus.rotations, 1);
        drive(5'b00100); edges(3);
        check("en_next_counts", bus.rotations, 2);

        // Saturation of the 4-bit instance
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        edges(1);
        check("sat_cleared", bus4.rotations, 0);
        pat = 5'b00100;
        for (int i = 0; i < 20; i++) begin
            pat = {pat[3:0], pat[4]};
            drive(pat);
            edges(4);
        end
        check("sat_rot16", bus.rotations, 20);
        check("sat_rot4", bus4.rotations, 15);
        check("sat_err4", bus4.errors, 0);
        check("sat_err16", bus.errors, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rotations", bus.rotations, 0);
        check("mid_rst_locked", bus.locked, 0);
        check("mid_rst_last", bus.last_pattern, 0);
        @(negedge clk);
        reset = 1'b1;
        edges(3);
        check("mid_rst_relock", bus.locked, 1);
        check("mid_rst_no_count", bus.rotations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_rotation_monitor.md
Name: gpio_rotation_monitor

Overview:
- Sits directly downstream of the one-hot rotating GPIO test pattern generator.
- Samples its output vector through a synchronizer and checks every change against the expected rotate-left step (MSB wraps to bit 0).
- Counts good rotations and sequence errors, and raises a sticky interrupt on error.
- Consumed by software/bench as status on the GPIO test path.

Parameters:
- WIDTH, 5, width of the monitored pattern vector.
- CNT_W, 16, width of the rotation and error counters.
- SYNC_STAGES, 2, input synchronizer depth (>=1).

Ports:
- clk  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- gpio_in  input  WIDTH  pattern from the generator, possibly asynchronous.
- enable  input  1  monitoring enable; low forces resync state and freezes counters.
- clear  input  1  synchronous one-cycle clear of counters, irq and FSM.
- rotations  output  CNT_W  count of correct rotation steps, saturating.
- errors  output  CNT_W  count of sequence errors, saturating.
- last_pattern  output  WIDTH  most recent synchronized sample.
- locked  output  1  high while FSM is in TRACK.
- err_pulse  output  1  one-cycle strobe per detected error.
- irq  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizer flops, prev sample, last_pattern, expected, counters, err_pulse, irq and locked all go to 0.
  - FSM goes to WAIT_INIT.
- Synchronizer:
  - sample = gpio_in delayed SYNC_STAGES flops.
  - last_pattern <= sample every cycle.
  - change = (sample != last_pattern).
- Latency: a gpio_in step reaches the counters/err_pulse SYNC_STAGES+1 cycles after the capturing edge (3 cycles at default).
- onehot(x) = exactly one bit set. rotl(x) = {x[WIDTH-2:0], x[WIDTH-1]}.
- FSM state WAIT_INIT:
  - If enable=1 and onehot(sample): expected <= rotl(sample), go to TRACK.
  - The initial lock is not counted as a rotation.
  - Non-one-hot samples, including all-zero, are ignored; no error is raised.
- FSM state TRACK (locked=1):
  - No change: hold.
  - change and sample==expected: rotations++, expected <= rotl(sample).
  - change and sample!=expected (wrong step, reverse step, multi-hot, zero): errors++, err_pulse=1 for one cycle, irq <= 1, go to WAIT_INIT.
  - The offending sample may itself relock on the following cycle if it is one-hot.
- enable=0:
  - FSM forced to WAIT_INIT; no counting and no errors.
  - irq and counters hold their values.
- Counters saturate at all-ones. Once errors has saturated, err_pulse and irq still assert on further errors.
- clear=1:
  - Next cycle rotations=0, errors=0, irq=0, err_pulse=0, FSM=WAIT_INIT.
  - clear has priority over a simultaneous count or error in the same cycle.
  - Synchronizer and last_pattern are not affected.
- Reset asserted mid-operation: immediate return to the reset values above. The relock after release uses the first one-hot sample seen.

Test Plan:
- Reset release, gpio_in=5'b10000, then four clean rotations 00001, 00010, 00100, 01000 spaced >=4 cycles apart -> locked=1 three cycles after reset release; rotations=4; errors=0; irq=0.
- Locked at 00010, drive 00001 (reverse step) -> err_pulse high for exactly one cycle, 3 cycles after the change; errors=1; irq=1; locked drops and then re-asserts, expecting 00010 next; rotations unchanged.
- Locked, drive 00000 then 01000 -> one error on the 00000 sample, relock at 01000, and the next 10000 counts one rotation.
- With CNT_W=4, 20 clean rotations -> rotations saturates at 15; errors=0.
- clear asserted in the same cycle an error is detected -> errors=0, irq=0, err_pulse=0 next cycle; FSM in WAIT_INIT.
- enable=0 while the pattern rotates 3 times -> rotations unchanged and locked=0. After enable=1, the first one-hot sample locks without a count, and the next step counts 1.
